// File: rtl/sprite_pos_scheduler.sv
// Round-robin collector of player/enemy/bullet position updates into a shadow set,
// committed to the live renderer-facing outputs once per frame at the vblank rising edge.
`timescale 1ns/1ps
module sprite_pos_scheduler #(
    parameter int X_MIN     = 21,
    parameter int X_MAX     = 609,
    parameter int Y_MIN     = 21,
    parameter int Y_MAX     = 459,
    parameter int PLAYER_X0 = 320,
    parameter int PLAYER_Y0 = 440,
    parameter int ENEMY_X0  = 320,
    parameter int ENEMY_Y0  = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        vblank,
    input  logic [2:0]  req,
    input  logic [29:0] req_x,
    input  logic [26:0] req_y,
    output logic [2:0]  gnt,
    output logic [9:0]  player_x,
    output logic [8:0]  player_y,
    output logic [9:0]  enemy_x,
    output logic [8:0]  enemy_y,
    output logic [9:0]  bullet_x,
    output logic [8:0]  bullet_y,
    output logic        bullet_live,
    output logic        frame_commit,
    output logic [2:0]  dirty,
    output logic [7:0]  overwrite_cnt
);

    localparam logic [9:0] XMIN_C = 10'(X_MIN);
    localparam logic [9:0] XMAX_C = 10'(X_MAX);
    localparam logic [8:0] YMIN_C = 9'(Y_MIN);
    localparam logic [8:0] YMAX_C = 9'(Y_MAX);
    localparam logic [9:0] PX0_C  = 10'(PLAYER_X0);
    localparam logic [8:0] PY0_C  = 9'(PLAYER_Y0);
    localparam logic [9:0] EX0_C  = 10'(ENEMY_X0);
    localparam logic [8:0] EY0_C  = 9'(ENEMY_Y0);

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_COMMIT = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    function automatic logic [9:0] clamp_x(input logic [9:0] v);
        logic [9:0] r;
        if (v < XMIN_C) begin
            r = XMIN_C;
        end else if (v > XMAX_C) begin
            r = XMAX_C;
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic [8:0] clamp_y(input logic [8:0] v);
        logic [8:0] r;
        if (v < YMIN_C) begin
            r = YMIN_C;
        end else if (v > YMAX_C) begin
            r = YMAX_C;
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic on_field(input logic [9:0] x, input logic [8:0] y);
        return (x >= XMIN_C) && (x <= XMAX_C) && (y >= YMIN_C) && (y <= YMAX_C);
    endfunction

    function automatic logic [1:0] inc_mod3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic        vblank_prev_q;

    logic [9:0]  sh_px_q, sh_px_d, sh_ex_q, sh_ex_d, sh_bx_q, sh_bx_d;
    logic [8:0]  sh_py_q, sh_py_d, sh_ey_q, sh_ey_d, sh_by_q, sh_by_d;
    logic        sh_blive_q, sh_blive_d;

    logic [9:0]  lv_px_q, lv_px_d, lv_ex_q, lv_ex_d, lv_bx_q, lv_bx_d;
    logic [8:0]  lv_py_q, lv_py_d, lv_ey_q, lv_ey_d, lv_by_q, lv_by_d;
    logic        lv_blive_q, lv_blive_d;

    logic [2:0]  dirty_q, dirty_d;
    logic [7:0]  ovr_q, ovr_d;
    logic        commit_q, commit_d;

    logic [2:0]  gnt_s;
    logic [1:0]  gidx_s;
    logic        found_s;
    logic [1:0]  cand_s;
    logic        rise_s;

    // Round-robin search starting just after the last granted requester; no grants in COMMIT or reset.
    always_comb begin
        gnt_s   = 3'b000;
        gidx_s  = 2'd0;
        found_s = 1'b0;
        cand_s  = inc_mod3(rr_ptr_q);
        if (!reset && (state_q != ST_COMMIT)) begin
            for (int k = 0; k < 3; k++) begin
                if (!found_s && req[cand_s]) begin
                    found_s = 1'b1;
                    gidx_s  = cand_s;
                end else begin
                    found_s = found_s;
                end
                cand_s = inc_mod3(cand_s);
            end
        end else begin
            found_s = 1'b0;
        end
        if (found_s) begin
            gnt_s = 3'b001 << gidx_s;
        end else begin
            gnt_s = 3'b000;
        end
    end

    assign rise_s = vblank && !vblank_prev_q;

    // Next-state computation: shadow writes, commit copy, frame state machine.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        sh_px_d    = sh_px_q;
        sh_py_d    = sh_py_q;
        sh_ex_d    = sh_ex_q;
        sh_ey_d    = sh_ey_q;
        sh_bx_d    = sh_bx_q;
        sh_by_d    = sh_by_q;
        sh_blive_d = sh_blive_q;
        lv_px_d    = lv_px_q;
        lv_py_d    = lv_py_q;
        lv_ex_d    = lv_ex_q;
        lv_ey_d    = lv_ey_q;
        lv_bx_d    = lv_bx_q;
        lv_by_d    = lv_by_q;
        lv_blive_d = lv_blive_q;
        dirty_d    = dirty_q;
        ovr_d      = ovr_q;
        commit_d   = (state_q == ST_COMMIT);

        if (found_s) begin
            rr_ptr_d        = gidx_s;
            dirty_d[gidx_s] = 1'b1;
            if (dirty_q[gidx_s] && (ovr_q != 8'd255)) begin
                ovr_d = ovr_q + 8'd1;
            end else begin
                ovr_d = ovr_q;
            end
            case (gidx_s)
                2'd0: begin
                    sh_px_d = clamp_x(req_x[9:0]);
                    sh_py_d = clamp_y(req_y[8:0]);
                end
                2'd1: begin
                    sh_ex_d = clamp_x(req_x[19:10]);
                    sh_ey_d = clamp_y(req_y[17:9]);
                end
                2'd2: begin
                    // Bullet keeps its raw position; off-field is signalled via bullet_live.
                    sh_bx_d    = req_x[29:20];
                    sh_by_d    = req_y[26:18];
                    sh_blive_d = on_field(req_x[29:20], req_y[26:18]);
                end
                default: begin
                    sh_px_d = sh_px_q;
                end
            endcase
        end else begin
            rr_ptr_d = rr_ptr_q;
        end

        case (state_q)
            ST_ACCEPT: begin
                // A grant taken on the rising-edge cycle counts toward the commit decision.
                if (rise_s) begin
                    state_d = ((dirty_q | gnt_s) != 3'b000) ? ST_COMMIT : ST_HOLD;
                end else begin
                    state_d = ST_ACCEPT;
                end
            end
            ST_COMMIT: begin
                lv_px_d    = sh_px_q;
                lv_py_d    = sh_py_q;
                lv_ex_d    = sh_ex_q;
                lv_ey_d    = sh_ey_q;
                lv_bx_d    = sh_bx_q;
                lv_by_d    = sh_by_q;
                lv_blive_d = sh_blive_q;
                dirty_d    = 3'b000;
                state_d    = vblank ? ST_HOLD : ST_ACCEPT;
            end
            ST_HOLD: begin
                if (!vblank) begin
                    state_d = ST_ACCEPT;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_ACCEPT;
            end
        endcase
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_ACCEPT;
            rr_ptr_q      <= 2'd2;
            vblank_prev_q <= 1'b1;
            sh_px_q       <= PX0_C;
            sh_py_q       <= PY0_C;
            sh_ex_q       <= EX0_C;
            sh_ey_q       <= EY0_C;
            sh_bx_q       <= 10'd0;
            sh_by_q       <= 9'd0;
            sh_blive_q    <= 1'b0;
            lv_px_q       <= PX0_C;
            lv_py_q       <= PY0_C;
            lv_ex_q       <= EX0_C;
            lv_ey_q       <= EY0_C;
            lv_bx_q       <= 10'd0;
            lv_by_q       <= 9'd0;
            lv_blive_q    <= 1'b0;
            dirty_q       <= 3'b000;
            ovr_q         <= 8'd0;
            commit_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            vblank_prev_q <= vblank;
            sh_px_q       <= sh_px_d;
            sh_py_q       <= sh_py_d;
            sh_ex_q       <= sh_ex_d;
            sh_ey_q       <= sh_ey_d;
            sh_bx_q       <= sh_bx_d;
            sh_by_q       <= sh_by_d;
            sh_blive_q    <= sh_blive_d;
            lv_px_q       <= lv_px_d;
            lv_py_q       <= lv_py_d;
            lv_ex_q       <= lv_ex_d;
            lv_ey_q       <= lv_ey_d;
            lv_bx_q       <= lv_bx_d;
            lv_by_q       <= lv_by_d;
            lv_blive_q    <= lv_blive_d;
            dirty_q       <= dirty_d;
            ovr_q         <= ovr_d;
            commit_q      <= commit_d;
        end
    end

    assign gnt           = gnt_s;
    assign player_x      = lv_px_q;
    assign player_y      = lv_py_q;
    assign enemy_x       = lv_ex_q;
    assign enemy_y       = lv_ey_q;
    assign bullet_x      = lv_bx_q;
    assign bullet_y      = lv_by_q;
    assign bullet_live   = lv_blive_q;
    assign frame_commit  = commit_q;
    assign dirty         = dirty_q;
    assign overwrite_cnt = ovr_q;

endmodule

// File: tb/tb_sprite_pos_scheduler.sv
// Directed, table-driven bench for sprite_pos_scheduler with hand-computed expectations.
`timescale 1ns/1ps
module tb_sprite_pos_scheduler;

    logic        clock;
    logic        reset;
    logic        vblank;
    logic [2:0]  req;
    logic [29:0] req_x;
    logic [26:0] req_y;
    logic [2:0]  gnt;
    logic [9:0]  player_x, enemy_x, bullet_x;
    logic [8:0]  player_y, enemy_y, bullet_y;
    logic        bullet_live;
    logic        frame_commit;
    logic [2:0]  dirty;
    logic [7:0]  overwrite_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    sprite_pos_scheduler dut (
        .clock        (clock),
        .reset        (reset),
        .vblank       (vblank),
        .req          (req),
        .req_x        (req_x),
        .req_y        (req_y),
        .gnt          (gnt),
        .player_x     (player_x),
        .player_y     (player_y),
        .enemy_x      (enemy_x),
        .enemy_y      (enemy_y),
        .bullet_x     (bullet_x),
        .bullet_y     (bullet_y),
        .bullet_live  (bullet_live),
        .frame_commit (frame_commit),
        .dirty        (dirty),
        .overwrite_cnt(overwrite_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int         idx;
        logic [9:0] x;
        logic [8:0] y;
        logic [9:0] ex;
        logic [8:0] ey;
        logic       el;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Single uncontended request: grant must appear the same cycle, then drop.
    task automatic drive_req(input int idx, input logic [9:0] x, input logic [8:0] y);
        req_x[idx*10 +: 10] = x;
        req_y[idx*9 +: 9]   = y;
        req = 3'b001 << idx;
        #1;
        check("gnt_single", {29'd0, gnt}, {29'd0, req});
        tick();
        req = 3'b000;
    endtask

    // Full vblank pulse with a pending shadow entry: COMMIT then frame_commit pulse.
    task automatic do_frame();
        vblank = 1'b1;
        tick();
        check("fc_commit_cycle", {31'd0, frame_commit}, 32'd0);
        tick();
        check("fc_pulse", {31'd0, frame_commit}, 32'd1);
        check("dirty_cleared", {29'd0, dirty}, 32'd0);
        vblank = 1'b0;
        tick();
        check("fc_pulse_end", {31'd0, frame_commit}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic check_defaults(input string tag);
        check({tag, "_px"}, {22'd0, player_x}, 32'd320);
        check({tag, "_py"}, {23'd0, player_y}, 32'd440);
        check({tag, "_ex"}, {22'd0, enemy_x}, 32'd320);
        check({tag, "_ey"}, {23'd0, enemy_y}, 32'd40);
        check({tag, "_blive"}, {31'd0, bullet_live}, 32'd0);
        check({tag, "_dirty"}, {29'd0, dirty}, 32'd0);
        check({tag, "_ovr"}, {24'd0, overwrite_cnt}, 32'd0);
        check({tag, "_fc"}, {31'd0, frame_commit}, 32'd0);
    endtask

    initial begin
        logic [2:0] exp_g[3];
        logic [9:0] ax;
        logic [8:0] ay;

        vecs[0] = '{1, 10'd700, 9'd30,  10'd609, 9'd30,  1'b0};
        vecs[1] = '{2, 10'd300, 9'd10,  10'd300, 9'd10,  1'b0};
        vecs[2] = '{2, 10'd300, 9'd200, 10'd300, 9'd200, 1'b1};
        vecs[3] = '{0, 10'd609, 9'd21,  10'd609, 9'd21,  1'b0};
        vecs[4] = '{1, 10'd20,  9'd460, 10'd21,  9'd459, 1'b0};
        vecs[5] = '{2, 10'd610, 9'd200, 10'd610, 9'd200, 1'b0};
        vecs[6] = '{2, 10'd21,  9'd459, 10'd21,  9'd459, 1'b1};
        vecs[7] = '{0, 10'd22,  9'd458, 10'd22,  9'd458, 1'b0};
        vecs[8] = '{2, 10'd0,   9'd0,   10'd0,   9'd0,   1'b0};
        exp_g[0] = 3'b001;
        exp_g[1] = 3'b010;
        exp_g[2] = 3'b100;

        reset = 1'b1; vblank = 1'b0; req = 3'b000; req_x = 30'd0; req_y = 27'd0;
        tick();
        tick();
        reset = 1'b0;

        // 1: reset state; vblank with nothing dirty gives no pulse
        check_defaults("rst");
        check("rst_gnt", {29'd0, gnt}, 32'd0);
        vblank = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_commit_clean", {31'd0, frame_commit}, 32'd0);
        end
        vblank = 1'b0;
        tick();
        tick();

        // 2: all three requesting -> round robin from requester 0
        req_x = {10'd50, 10'd400, 10'd100};
        req_y = {9'd60, 9'd100, 9'd200};
        req = 3'b111;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("rr_gnt", {29'd0, gnt}, {29'd0, exp_g[i]});
            tick();
            req = req & ~exp_g[i];
        end
        check("rr_dirty", {29'd0, dirty}, 32'd7);
        check("rr_live_px_held", {22'd0, player_x}, 32'd320);
        vblank = 1'b1;
        tick();
        req_x[9:0] = 10'd5;
        req_y[8:0] = 9'd470;
        req = 3'b001;
        #1;
        check("commit_gnt0", {29'd0, gnt}, 32'd0);
        tick();
        check("rr_fc", {31'd0, frame_commit}, 32'd1);
        check("rr_px", {22'd0, player_x}, 32'd100);
        check("rr_py", {23'd0, player_y}, 32'd200);
        check("rr_ex", {22'd0, enemy_x}, 32'd400);
        check("rr_ey", {23'd0, enemy_y}, 32'd100);
        check("rr_bx", {22'd0, bullet_x}, 32'd50);
        check("rr_by", {23'd0, bullet_y}, 32'd60);
        check("rr_blive", {31'd0, bullet_live}, 32'd1);
        check("hold_gnt", {29'd0, gnt}, 32'd1);
        tick();
        req = 3'b000;
        check("hold_dirty", {29'd0, dirty}, 32'd1);
        check("hold_fc_end", {31'd0, frame_commit}, 32'd0);
        check("hold_px_held", {22'd0, player_x}, 32'd100);
        vblank = 1'b0;
        tick();

        // 3: the HOLD grant (5,470) commits clamped
        do_frame();
        check("clamp_px", {22'd0, player_x}, 32'd21);
        check("clamp_py", {23'd0, player_y}, 32'd459);

        // 3/4: table of single updates, each followed by a commit
        for (int i = 0; i < 9; i++) begin
            drive_req(vecs[i].idx, vecs[i].x, vecs[i].y);
            do_frame();
            case (vecs[i].idx)
                0: begin ax = player_x; ay = player_y; end
                1: begin ax = enemy_x;  ay = enemy_y;  end
                default: begin ax = bullet_x; ay = bullet_y; end
            endcase
            check($sformatf("vec%0d_x", i), {22'd0, ax}, {22'd0, vecs[i].ex});
            check($sformatf("vec%0d_y", i), {23'd0, ay}, {23'd0, vecs[i].ey});
            if (vecs[i].idx == 2) begin
                check($sformatf("vec%0d_live", i), {31'd0, bullet_live}, {31'd0, vecs[i].el});
            end
        end
        check("tbl_ovr", {24'd0, overwrite_cnt}, 32'd0);

        // 5: overwrites before commit
        do_reset();
        drive_req(0, 10'd100, 9'd200);
        tick();
        drive_req(0, 10'd110, 9'd200);
        tick();
        drive_req(0, 10'd120, 9'd200);
        check("ovr_cnt2", {24'd0, overwrite_cnt}, 32'd2);
        check("ovr_dirty", {29'd0, dirty}, 32'd1);
        do_frame();
        check("ovr_px", {22'd0, player_x}, 32'd120);
        check("ovr_cnt_kept", {24'd0, overwrite_cnt}, 32'd2);

        // 5: request on the exact vblank-rise cycle, nothing else dirty
        tick();
        req_x[9:0] = 10'd140;
        req_y[8:0] = 9'd200;
        req = 3'b001;
        vblank = 1'b1;
        #1;
        check("rise_gnt", {29'd0, gnt}, 32'd1);
        tick();
        req = 3'b000;
        tick();
        check("rise_fc", {31'd0, frame_commit}, 32'd1);
        check("rise_px", {22'd0, player_x}, 32'd140);
        vblank = 1'b0;
        tick();
        tick();

        // saturation of overwrite_cnt
        for (int i = 0; i < 258; i++) begin
            drive_req(0, 10'd300, 9'd200);
        end
        check("ovr_sat", {24'd0, overwrite_cnt}, 32'd255);
        do_frame();
        check("sat_px", {22'd0, player_x}, 32'd300);

        // 6: reset during COMMIT
        drive_req(0, 10'd200, 9'd200);
        vblank = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_defaults("rstc");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rstc_no_fc", {31'd0, frame_commit}, 32'd0);
        end
        drive_req(0, 10'd250, 9'd300);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rstc_no_fc_dirty", {31'd0, frame_commit}, 32'd0);
            check("rstc_px_held", {22'd0, player_x}, 32'd320);
        end
        vblank = 1'b0;
        tick();
        do_frame();
        check("rstc_after_px", {22'd0, player_x}, 32'd250);
        check("rstc_after_py", {23'd0, player_y}, 32'd300);

        // 6: reset during HOLD with vblank high
        vblank = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_defaults("rsth");
        drive_req(1, 10'd100, 9'd100);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rsth_no_fc", {31'd0, frame_commit}, 32'd0);
        end
        check("rsth_ex_held", {22'd0, enemy_x}, 32'd320);
        vblank = 1'b0;
        tick();
        do_frame();
        check("rsth_after_ex", {22'd0, enemy_x}, 32'd100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
